t03_nes_poll_sequencer: RTL and testbench

Owns the shared NES controller bus: one latch line and one pulse line fan out to both controllers, and each controller returns its own serial data line. The block sequences the latch/pulse protocol and shifts in both 8-bit button words. It publishes active-high snapshots plus newly-pressed edge masks to the game logic over a valid/ready handshake. Polls are triggered on request or by an internal auto-poll timer; this block replaces the free-running clock divider and shift registers on the controller path.

---
 rtl/t03_nes_pkg.sv | 28 ++
 rtl/t03_nes_rx_lane.sv | 45 ++++
 rtl/t03_nes_poll_sequencer.sv | 165 ++++++++++++++++
 tb/tb_t03_nes_poll_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_nes_pkg.sv
// Shared definitions for the NES controller poll sequencer.
//   nes_state_t      : sequencer FSM states
//   BTN_*            : bit index of each button in a controller word
//   DEF_*            : default timing constants
package t03_nes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    PULSE_HI = 3'd2,
    PULSE_LO = 3'd3,
    DONE     = 3'd4
  } nes_state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam logic [15:0] DEF_HALF_CYC    = 16'd500;
  localparam logic [23:0] DEF_AUTO_PERIOD = 24'd166667;
  localparam int          DEF_NBTN        = 8;

endpackage

// File: rtl/t03_nes_rx_lane.sv
// One controller's receive path.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   data_n     : raw serial data from controller (active-low, asynchronous)
//   sample_en  : shift one synchronized, inverted bit into the shift register
//   commit     : publish shift register as btn and update the rise mask
//   btn        : pressed mask (active-high)
//   rise       : buttons pressed now that were released in the previous commit
module t03_nes_rx_lane #(
  parameter int NBTN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_n,
  input  logic            sample_en,
  input  logic            commit,
  output logic [NBTN-1:0] btn,
  output logic [NBTN-1:0] rise
);

  logic [1:0]      sync_q;
  logic [NBTN-1:0] shreg;
  logic [NBTN-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle (released) line level.
      sync_q <= 2'b11;
      shreg  <= '0;
      prev   <= '0;
      btn    <= '0;
      rise   <= '0;
    end else begin
      sync_q <= {sync_q[0], data_n};
      // First sampled bit (A) ends up in the MSB after NBTN shifts.
      if (sample_en) shreg <= {shreg[NBTN-2:0], ~sync_q[1]};
      if (commit) begin
        btn  <= shreg;
        rise <= shreg & ~prev;
        prev <= shreg;
      end
    end
  end

endmodule

// File: rtl/t03_nes_poll_sequencer.sv
// NES controller poll sequencer: drives the shared latch/pulse lines, shifts in
// both controllers' button words and publishes snapshots over valid/ready.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   poll_req              : single-cycle poll request
//   data1, data2          : controller serial data (active-low, async)
//   latch, pulse          : NES bus outputs (registered, never both high)
//   busy                  : FSM not IDLE
//   snap_valid/snap_ready : snapshot handshake
//   p1_btn, p2_btn        : pressed masks
//   p1_rise, p2_rise      : newly-pressed masks
//   overrun               : one-cycle pulse when an unaccepted snapshot is overwritten
//   dbg_state             : current FSM state (nes_state_t encoding)
//
// Handshake: a snapshot is transferred on any cycle where snap_valid and
// snap_ready are both high; snap_valid drops the following cycle unless a new
// snapshot completes on that same cycle, in which case the new one stays valid.
// Snapshot outputs only change while snap_valid=1 when a new snapshot lands.
module t03_nes_poll_sequencer
  import t03_nes_pkg::*;
#(
  parameter logic [15:0] HALF_CYC    = DEF_HALF_CYC,
  parameter logic [23:0] AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int          NBTN        = DEF_NBTN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       data1,
  input  logic       data2,
  output logic       latch,
  output logic       pulse,
  output logic       busy,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic [7:0] p1_btn,
  output logic [7:0] p2_btn,
  output logic [7:0] p1_rise,
  output logic [7:0] p2_rise,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  // Counter is one bit wider than HALF_CYC so the latch phase cannot overflow.
  localparam logic [16:0] LATCH_LAST = {HALF_CYC, 1'b0} - 17'd1;
  localparam logic [16:0] HALF_LAST  = {1'b0, HALF_CYC} - 17'd1;
  localparam logic        AUTO_EN    = (AUTO_PERIOD != 24'd0);
  localparam logic [23:0] AUTO_LAST  = AUTO_PERIOD - 24'd1;

  nes_state_t  state;
  logic [16:0] cnt;
  logic [3:0]  k;
  logic        pending;
  logic [23:0] auto_cnt;
  logic        auto_exp;
  logic        trigger;
  logic        sample_en;
  logic        commit;

  assign auto_exp  = AUTO_EN && (auto_cnt == AUTO_LAST);
  assign trigger   = poll_req | auto_exp | pending;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign commit    = (state == DONE);
  // Bit A is taken at the end of latch; bits 6..0 at the end of pulses 1..7.
  assign sample_en = ((state == LATCH) && (cnt == LATCH_LAST)) ||
                     ((state == PULSE_LO) && (cnt == HALF_LAST) && (k <= 4'(BTN_A)));

  // Free-running auto-poll timer, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst || !AUTO_EN || auto_exp) auto_cnt <= '0;
    else                             auto_cnt <= auto_cnt + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      k          <= '0;
      pending    <= 1'b0;
      latch      <= 1'b0;
      pulse      <= 1'b0;
      snap_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (snap_valid && snap_ready) snap_valid <= 1'b0;
      // One-deep request memory while a poll is running.
      if ((state != IDLE) && (poll_req || auto_exp)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            state   <= LATCH;
            latch   <= 1'b1;
            cnt     <= '0;
            pending <= 1'b0;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state <= PULSE_HI;
            latch <= 1'b0;
            pulse <= 1'b1;
            cnt   <= '0;
            k     <= 4'd1;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        PULSE_HI: begin
          if (cnt == HALF_LAST) begin
            state <= PULSE_LO;
            pulse <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        PULSE_LO: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (k < 4'(NBTN)) begin
              k     <= k + 4'd1;
              pulse <= 1'b1;
              state <= PULSE_HI;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        DONE: begin
          // A same-cycle accept takes the old snapshot; the new one stays valid.
          snap_valid <= 1'b1;
          overrun    <= snap_valid && !snap_ready;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  t03_nes_rx_lane #(.NBTN(NBTN)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .data_n    (data1),
    .sample_en (sample_en),
    .commit    (commit),
    .btn       (p1_btn),
    .rise      (p1_rise)
  );

  t03_nes_rx_lane #(.NBTN(NBTN)) u_lane2 (
    .clk       (clk),
    .rst       (rst),
    .data_n    (data2),
    .sample_en (sample_en),
    .commit    (commit),
    .btn       (p2_btn),
    .rise      (p2_rise)
  );

endmodule

// File: tb/tb_t03_nes_poll_sequencer.sv
module tb_t03_nes_poll_sequencer;
  import t03_nes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       poll_req = 1'b0;
  logic       snap_ready = 1'b0;
  logic       data1, data2;
  logic       latch, pulse, busy, snap_valid, overrun;
  logic [7:0] p1_btn, p2_btn, p1_rise, p2_rise;
  logic [2:0] dbg_state;

  // Second instance with auto-poll enabled and both controllers unplugged.
  logic       rst_a = 1'b1;
  logic       poll_req_a = 1'b0;
  logic       snap_ready_a = 1'b1;
  logic       data1_a = 1'b1, data2_a = 1'b1;
  logic       latch_a, pulse_a, busy_a, snap_valid_a, overrun_a;
  logic [7:0] p1_btn_a, p2_btn_a, p1_rise_a, p2_rise_a;
  logic [2:0] dbg_state_a;

  t03_nes_poll_sequencer #(.HALF_CYC(16'd4), .AUTO_PERIOD(24'd0), .NBTN(8)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req), .data1(data1), .data2(data2),
    .latch(latch), .pulse(pulse), .busy(busy), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_rise(p1_rise), .p2_rise(p2_rise), .overrun(overrun), .dbg_state(dbg_state)
  );

  t03_nes_poll_sequencer #(.HALF_CYC(16'd4), .AUTO_PERIOD(24'd200), .NBTN(8)) dut_a (
    .clk(clk), .rst(rst_a), .poll_req(poll_req_a), .data1(data1_a), .data2(data2_a),
    .latch(latch_a), .pulse(pulse_a), .busy(busy_a), .snap_valid(snap_valid_a),
    .snap_ready(snap_ready_a), .p1_btn(p1_btn_a), .p2_btn(p2_btn_a),
    .p1_rise(p1_rise_a), .p2_rise(p2_rise_a), .overrun(overrun_a), .dbg_state(dbg_state_a)
  );

  // ---------------- controller model (4021-style shift register) ----------------
  logic [7:0] pat1 = 8'hFF, pat2 = 8'hFF;  // active-low line patterns, bit7 first
  logic [7:0] sh1 = 8'hFF, sh2 = 8'hFF;
  logic       pulse_q = 1'b0;

  always @(posedge clk) begin
    if (latch) begin
      sh1 <= pat1;
      sh2 <= pat2;
    end else if (pulse && !pulse_q) begin
      sh1 <= {sh1[6:0], 1'b1};
      sh2 <= {sh2[6:0], 1'b1};
    end
    pulse_q <= pulse;
  end
  assign data1 = sh1[7];
  assign data2 = sh2[7];

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lines(input logic [7:0] pressed);
    return ~pressed;
  endfunction

  // Pulse poll_req, then run until the FSM returns to IDLE; n = cycles from request.
  task automatic do_poll(output int n);
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    n = 1;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, nrise, c, rises, second_at, first_at, nsv;
    logic lat_ok, sv_early, overlap, pr, lp;
    logic [7:0] m_a, m_b, m_start, m_right;

    m_a     = 8'd1 << BTN_A;
    m_b     = 8'd1 << BTN_B;
    m_start = 8'd1 << BTN_START;
    m_right = 8'd1 << BTN_RIGHT;

    // Reset then idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rst_latch", latch, 0);
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", snap_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_p1_btn", p1_btn, 0);
    check("rst_p2_btn", p2_btn, 0);
    check("rst_p1_rise", p1_rise, 0);
    check("rst_state", dbg_state, IDLE);

    // Single poll: p1 A+Start, p2 nothing
    pat1 = lines(m_a | m_start);
    pat2 = lines(8'h00);
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    lat_ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (!(latch && !pulse && busy)) lat_ok = 1'b0;
      tick();
    end
    check("latch_window", lat_ok, 1);
    check("c9_latch", latch, 0);
    nrise = 0; pr = 1'b0; sv_early = 1'b0; overlap = 1'b0;
    for (int i = 9; i <= 73; i++) begin
      if (pulse && !pr) nrise++;
      pr = pulse;
      if (latch && pulse) overlap = 1'b1;
      if (snap_valid) sv_early = 1'b1;
      tick();
    end
    check("pulse_count", nrise, 8);
    check("latch_pulse_overlap", overlap, 0);
    check("valid_early", sv_early, 0);
    check("c74_valid", snap_valid, 1);
    check("c74_busy", busy, 0);
    check("p1_btn_1", p1_btn, 8'h90);
    check("p2_btn_1", p2_btn, 8'h00);
    check("p1_rise_1", p1_rise, 8'h90);
    check("p2_rise_1", p2_rise, 8'h00);
    check("overrun_1", overrun, 0);
    tick();
    check("hold_valid", snap_valid, 1);
    check("hold_p1_btn", p1_btn, 8'h90);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    check("accept_clears", snap_valid, 0);

    // Edge mask: A held, Start released, B pressed
    pat1 = lines(m_a | m_b);
    do_poll(n);
    check("poll2_len", n, 74);
    check("p1_btn_2", p1_btn, 8'hC0);
    check("p1_rise_2", p1_rise, 8'h40);
    check("overrun_2", overrun, 0);

    // Overrun: snapshot still unaccepted when the next one completes
    pat1 = lines(m_right);
    pat2 = lines(m_a);
    do_poll(n);
    check("poll3_len", n, 74);
    check("overrun_3", overrun, 1);
    check("p1_btn_3", p1_btn, 8'h01);
    check("p1_rise_3", p1_rise, 8'h01);
    check("p2_btn_3", p2_btn, 8'h80);
    check("p2_rise_3", p2_rise, 8'h80);
    tick();
    check("overrun_one_cycle", overrun, 0);
    check("valid_after_overrun", snap_valid, 1);
    snap_ready = 1'b1;
    tick();
    check("accept_after_overrun", snap_valid, 0);

    // Pending: two extra requests while busy yield exactly one follow-on poll
    poll_req = 1'b1;
    lp = latch;
    rises = 0; second_at = 0; nsv = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      poll_req = (i == 10 || i == 20);
      if (latch && !lp) begin
        rises++;
        if (rises == 2) second_at = i;
      end
      lp = latch;
      if (snap_valid) nsv++;
    end
    check("pending_polls", rises, 2);
    check("pending_start", second_at, 75);
    check("pending_valid_cycles", nsv, 2);

    // Reset in the middle of PULSE_HI
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (9) tick();
    check("mid_in_pulse_hi", pulse, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_latch", latch, 0);
    check("mid_rst_pulse", pulse, 0);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_valid", snap_valid, 0);
    check("mid_rst_p1_btn", p1_btn, 0);
    snap_ready = 1'b0;
    pat1 = lines(m_a | m_start);
    pat2 = lines(8'h00);
    do_poll(n);
    check("post_rst_len", n, 74);
    check("post_rst_p1_btn", p1_btn, 8'h90);
    check("post_rst_p1_rise", p1_rise, 8'h90);

    // Auto-poll on the second instance, unplugged controllers
    rst_a = 1'b0;
    lp = latch_a;
    rises = 0; first_at = 0; second_at = 0; nsv = 0;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (latch_a && !lp) begin
        rises++;
        if (rises == 1) first_at = i;
        if (rises == 2) second_at = i;
      end
      lp = latch_a;
      if (snap_valid_a) nsv++;
    end
    check("auto_first", first_at, 200);
    check("auto_second", second_at, 400);
    check("auto_count", rises, 3);
    check("auto_valid_cycles", nsv, 3);
    check("unplugged_p1", p1_btn_a, 8'h00);
    check("unplugged_p2", p2_btn_a, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
